// File: rtl/cdc_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cdc_fifo_wr_ctrl
// Description : Write-side controller of an asynchronous FIFO. Generates RAM
//               write strobe/address and the binary/gray write pointers,
//               derives fill level and full from the synchronised read
//               pointer, and sequences the flush/drain handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_fifo_wr_ctrl #(
    parameter int ADDR_WIDTH  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  sysRst,
    input  logic                  wrValid,
    output logic                  wrReady,
    output logic                  wrEn,
    output logic [ADDR_WIDTH-1:0] wrAddr,
    output logic [ADDR_WIDTH:0]   wrPtrGray,
    input  logic [ADDR_WIDTH:0]   rdPtrGrayAsync,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    input  logic                  flushReq,
    output logic                  flushAck
);

    localparam int                c_PTR_W    = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] c_FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_WIDTH:0] r_wrBin;
    logic [ADDR_WIDTH:0] r_wrGray;
    logic [ADDR_WIDTH:0] r_rdSync [SYNC_STAGES];
    logic                r_flushAck;

    logic [ADDR_WIDTH:0] w_rdGraySync;
    logic [ADDR_WIDTH:0] w_rdBin;
    logic [ADDR_WIDTH:0] w_level;
    logic [ADDR_WIDTH:0] w_wrBinNext;
    logic                w_full;
    logic                w_fullGray;
    logic                w_wrReady;
    logic                w_wrEn;

    assign w_rdGraySync = r_rdSync[SYNC_STAGES-1];

    // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        w_rdBin = '0;
        for (int i = 0; i < c_PTR_W; i++) begin
            w_rdBin[i] = ^(w_rdGraySync >> i);
        end
    end

    assign w_level     = r_wrBin - w_rdBin;
    assign w_full      = (w_level == c_FULL_LVL);
    assign w_fullGray  = (r_wrGray == {~w_rdGraySync[ADDR_WIDTH:ADDR_WIDTH-1],
                                       w_rdGraySync[ADDR_WIDTH-2:0]});
    assign w_wrReady   = (r_state == S_RUN) & ~w_full & ~flushReq;
    assign w_wrEn      = wrValid & w_wrReady;
    assign w_wrBinNext = r_wrBin + c_ONE;

    always_ff @(posedge clk) begin
        if (sysRst) begin
            r_wrBin  <= '0;
            r_wrGray <= '0;
        end else if (w_wrEn) begin
            r_wrBin  <= w_wrBinNext;
            r_wrGray <= w_wrBinNext ^ (w_wrBinNext >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (sysRst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_rdSync[i] <= '0;
            end
        end else begin
            r_rdSync[0] <= rdPtrGrayAsync;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_rdSync[i] <= r_rdSync[i-1];
            end
        end
    end

    // Pointers are never touched by a flush; the reader drains to our pointer.
    always_ff @(posedge clk) begin
        if (sysRst) begin
            r_state    <= S_RUN;
            r_flushAck <= 1'b0;
        end else begin
            r_flushAck <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (flushReq) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_level == '0) begin
                        r_state    <= S_ACK;
                        r_flushAck <= 1'b1;
                    end
                end
                S_ACK: begin
                    r_state <= S_RUN;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!sysRst) begin
            assert (w_full == w_fullGray);
        end
    end

    assign wrReady   = w_wrReady;
    assign wrEn      = w_wrEn;
    assign wrAddr    = r_wrBin[ADDR_WIDTH-1:0];
    assign wrPtrGray = r_wrGray;
    assign level     = w_level;
    assign full      = w_full;
    assign flushAck  = r_flushAck;

endmodule
`default_nettype wire

// File: tb/tb_cdc_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_fifo_wr_ctrl
// Description : Self-checking bench: vector table for fill/full/sync latency,
//               hand sequences for wrap, flush and reset-during-drain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_fifo_wr_ctrl;

    logic       clk = 1'b0;
    logic       sysRst;
    logic       wrValid;
    logic       wrReady;
    logic       wrEn;
    logic [2:0] wrAddr;
    logic [3:0] wrPtrGray;
    logic [3:0] rdPtrGrayAsync;
    logic [3:0] level;
    logic       full;
    logic       flushReq;
    logic       flushAck;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cdc_fifo_wr_ctrl #(.ADDR_WIDTH(3), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .sysRst         (sysRst),
        .wrValid        (wrValid),
        .wrReady        (wrReady),
        .wrEn           (wrEn),
        .wrAddr         (wrAddr),
        .wrPtrGray      (wrPtrGray),
        .rdPtrGrayAsync (rdPtrGrayAsync),
        .level          (level),
        .full           (full),
        .flushReq       (flushReq),
        .flushAck       (flushAck)
    );

    typedef struct {
        logic       wv;
        logic       fr;
        logic [3:0] rp;
        logic       rdy;
        logic       en;
        logic [2:0] addr;
        logic [3:0] gray;
        logic [3:0] lvl;
        logic       full;
        logic       ack;
    } vec_t;

    vec_t       vecs [14];
    logic [3:0] gseq [8];

    function automatic logic [3:0] g(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive inputs just after the falling edge and let outputs settle.
    task automatic drive(input logic wv, input logic fr, input logic [3:0] rp);
        @(negedge clk);
        wrValid        = wv;
        flushReq       = fr;
        rdPtrGrayAsync = rp;
        #1;
    endtask

    function automatic vec_t mk(input logic wv, input logic fr, input logic [3:0] rp,
                                input logic rdy, input logic en, input logic [2:0] addr,
                                input logic [3:0] gray, input logic [3:0] lvl,
                                input logic fl, input logic ack);
        vec_t v;
        v.wv = wv; v.fr = fr; v.rp = rp; v.rdy = rdy; v.en = en; v.addr = addr;
        v.gray = gray; v.lvl = lvl; v.full = fl; v.ack = ack;
        return v;
    endfunction

    initial begin
        int m;
        int pulses;
        int ack_at;

        gseq = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4};
        vecs[0] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            vecs[k+1] = mk(1, 0, 0, 1, 1, 3'(k), gseq[k], 4'(k), 0, 0);
        end
        vecs[9]  = mk(1, 0, 0, 0, 0, 0, 12, 8, 1, 0);
        vecs[10] = mk(1, 0, 1, 0, 0, 0, 12, 8, 1, 0);
        vecs[11] = mk(1, 0, 1, 0, 0, 0, 12, 8, 1, 0);
        vecs[12] = mk(1, 0, 1, 1, 1, 0, 12, 7, 0, 0);
        vecs[13] = mk(0, 0, 1, 0, 0, 1, 13, 8, 1, 0);

        sysRst = 1'b1; wrValid = 1'b0; flushReq = 1'b0; rdPtrGrayAsync = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sysRst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].wv, vecs[i].fr, vecs[i].rp);
            chk($sformatf("v%0d wrReady", i),   wrReady,   vecs[i].rdy);
            chk($sformatf("v%0d wrEn", i),      wrEn,      vecs[i].en);
            chk($sformatf("v%0d wrAddr", i),    wrAddr,    vecs[i].addr);
            chk($sformatf("v%0d wrPtrGray", i), wrPtrGray, vecs[i].gray);
            chk($sformatf("v%0d level", i),     level,     vecs[i].lvl);
            chk($sformatf("v%0d full", i),      full,      vecs[i].full);
            chk($sformatf("v%0d flushAck", i),  flushAck,  vecs[i].ack);
        end

        // Drain the reader to wrBin=9, then 20 write/read pairs across the wrap.
        m = 9;
        drive(0, 0, g(9));
        drive(0, 0, g(9));
        drive(0, 0, g(9));
        chk("drain level", level, 0);
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, g(m));
            chk("wrap wrEn", wrEn, 1);
            chk("wrap wrAddr", wrAddr, m % 8);
            chk("wrap gray", wrPtrGray, g(m));
            chk("wrap level<=1", int'(level <= 4'd1), 1);
            chk("wrap full", full, 0);
            m = (m + 1) % 16;
            for (int j = 0; j < 3; j++) begin
                drive(0, 0, g(m));
                chk("wrap gray after", wrPtrGray, g(m));
                chk("wrap idle level<=1", int'(level <= 4'd1), 1);
                chk("wrap idle full", full, 0);
            end
        end
        chk("wrap final bin", m, 13);

        // Flush with three entries outstanding.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, g(13));
            chk("pre-flush wrEn", wrEn, 1);
        end
        drive(1, 1, g(13));
        chk("flush wins wrEn", wrEn, 0);
        chk("flush level", level, 3);
        drive(1, 0, g(13));
        chk("drain wrReady", wrReady, 0);
        chk("drain wrEn", wrEn, 0);
        chk("drain gray", wrPtrGray, g(0));
        pulses = 0;
        ack_at = -1;
        for (int j = 0; j < 6; j++) begin
            drive(0, 0, g(0));
            if (flushAck) begin
                pulses++;
                if (ack_at < 0) ack_at = j;
            end
            if (j == 4) chk("post-ack wrReady", wrReady, 1);
        end
        chk("flush ack pulses", pulses, 1);
        chk("flush ack cycle", ack_at, 3);

        // Flush when already empty.
        drive(0, 1, g(0));
        chk("empty flush wrReady", wrReady, 0);
        chk("empty flush ack0", flushAck, 0);
        drive(0, 0, g(0));
        chk("empty flush ack1", flushAck, 0);
        drive(0, 0, g(0));
        chk("empty flush ack2", flushAck, 1);
        drive(0, 0, g(0));
        chk("empty flush ack3", flushAck, 0);
        chk("empty flush wrReady", wrReady, 1);

        // Reset while draining with five entries.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, g(0));
        end
        drive(0, 1, g(0));
        chk("rst-drain level", level, 5);
        chk("rst-drain gray", wrPtrGray, g(5));
        drive(0, 0, g(0));
        chk("rst-drain wrReady", wrReady, 0);
        @(negedge clk);
        sysRst = 1'b1;
        @(negedge clk);
        sysRst = 1'b0;
        #1;
        chk("post-rst level", level, 0);
        chk("post-rst gray", wrPtrGray, 0);
        chk("post-rst flushAck", flushAck, 0);
        chk("post-rst wrReady", wrReady, 1);
        chk("post-rst full", full, 0);
        drive(1, 0, g(0));
        chk("post-rst wrEn", wrEn, 1);
        chk("post-rst wrAddr", wrAddr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
